cpu_bus_master: RTL and testbench

Parametrised memory-access front end shared by CPU pipeline stages. It accepts word accesses from NUM_CH requesting channels (instruction fetch, data memory, future DMA/debug), arbitrates them round-robin, and routes each access either to the scratch-pad memory (SPM) port or to one master port of the system bus. It generalises the fixed per-stage bus interface with a configurable channel count, configurable widths, and a bus-wait timeout that returns an error instead of hanging the pipeline.

---
 rtl/cpu_bus_pkg.sv | 28 ++
 rtl/cpu_bus_master_if.sv | 46 ++++
 rtl/rr_arbiter.sv | 32 +++
 rtl/cpu_bus_master.sv | 181 ++++++++++++++++++
 tb/tb_cpu_bus_master.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the CPU memory-access front end: state encoding,
// direction codes, SPM tag default and active-low strobe levels.
package cpu_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SPM,
    ST_SPM_RD,
    ST_BUS_REQ,
    ST_BUS_AS,
    ST_BUS_WAIT,
    ST_DONE
  } bus_state_e;

  localparam logic READ  = 1'b1;
  localparam logic WRITE = 1'b0;

  localparam logic [2:0] SPM_TAG_DEFAULT = 3'b011;

  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  // Index width that stays at least one bit wide for a single channel.
  function automatic int idxWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cpu_bus_master_if.sv
// Channel, SPM and system-bus signal bundle of cpu_bus_master.
// The master modport is the front end itself; slave is its environment.
interface cpu_bus_master_if #(
  parameter int NUM_CH     = 2,
  parameter int ADDR_W     = 30,
  parameter int DATA_W     = 32,
  parameter int SPM_ADDR_W = 12
);

  logic [NUM_CH-1:0]        ChReq;
  logic [NUM_CH*ADDR_W-1:0] ChAddr;
  logic [NUM_CH-1:0]        ChRW;
  logic [NUM_CH*DATA_W-1:0] ChWrData;
  logic [NUM_CH-1:0]        ChAck;
  logic                     ChErr;
  logic [DATA_W-1:0]        RdData;
  logic                     Busy;

  logic [SPM_ADDR_W-1:0]    SPMAddr;
  logic                     SPMAs_;
  logic                     SPMRW;
  logic [DATA_W-1:0]        SPMWrData;
  logic [DATA_W-1:0]        SPMRdData;

  logic                     BusReq_;
  logic                     BusGrnt_;
  logic [ADDR_W-1:0]        BusAddr;
  logic                     BusAs_;
  logic                     BusRW;
  logic [DATA_W-1:0]        BusWrData;
  logic [DATA_W-1:0]        BusRdData;
  logic                     BusRdy_;

  modport master (
    input  ChReq, ChAddr, ChRW, ChWrData, SPMRdData, BusGrnt_, BusRdData, BusRdy_,
    output ChAck, ChErr, RdData, Busy, SPMAddr, SPMAs_, SPMRW, SPMWrData,
           BusReq_, BusAddr, BusAs_, BusRW, BusWrData
  );

  modport slave (
    output ChReq, ChAddr, ChRW, ChWrData, SPMRdData, BusGrnt_, BusRdData, BusRdy_,
    input  ChAck, ChErr, RdData, Busy, SPMAddr, SPMAs_, SPMRW, SPMWrData,
           BusReq_, BusAddr, BusAs_, BusRW, BusWrData
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requesting channel at or after
// the pointer, returned both one-hot and as an index.
module rr_arbiter #(
  parameter int NUM_CH = 2,
  parameter int IDX_W  = 1
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [IDX_W-1:0]  ptr_i,
  output logic [NUM_CH-1:0] grant_o,
  output logic [IDX_W-1:0]  idx_o,
  output logic              valid_o
);

  logic [IDX_W-1:0] cand;

  // Walk the channels starting at the pointer; the first hit wins.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      cand = IDX_W'((int'(ptr_i) + k) % NUM_CH);
      if (!valid_o && req_i[cand]) begin
        grant_o[cand] = 1'b1;
        idx_o         = cand;
        valid_o       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cpu_bus_master.sv
// Memory-access front end: round-robin over NUM_CH channels, routes each
// word access to the scratch-pad or the system bus, with a bus-wait timeout.
module cpu_bus_master
  import cpu_bus_pkg::*;
#(
  parameter int         NUM_CH     = 2,
  parameter int         ADDR_W     = 30,
  parameter int         DATA_W     = 32,
  parameter int         SPM_ADDR_W = 12,
  parameter logic [2:0] SPM_TAG    = SPM_TAG_DEFAULT,
  parameter int         TIMEOUT    = 255
) (
  input logic              clk,
  input logic              reset,
  cpu_bus_master_if.master bus
);

  localparam int IDX_W = idxWidth(NUM_CH);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  bus_state_e            state_q;
  logic [IDX_W-1:0]      ptr_q;
  logic [NUM_CH-1:0]     selOh_q;
  logic [ADDR_W-1:0]     addr_q;
  logic                  rw_q;
  logic [DATA_W-1:0]     wrData_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [NUM_CH-1:0]     chAck_q;
  logic                  chErr_q;
  logic [DATA_W-1:0]     rdData_q;
  logic                  busy_q;
  logic [SPM_ADDR_W-1:0] spmAddr_q;
  logic                  spmAs_q;
  logic                  spmRW_q;
  logic [DATA_W-1:0]     spmWrData_q;
  logic                  busReq_q;
  logic [ADDR_W-1:0]     busAddr_q;
  logic                  busAs_q;
  logic                  busRW_q;
  logic [DATA_W-1:0]     busWrData_q;

  logic [NUM_CH-1:0]     arbGrant;
  logic [IDX_W-1:0]      arbIdx;
  logic                  arbValid;
  logic [ADDR_W-1:0]     pickAddr;
  logic                  pickRW;
  logic [DATA_W-1:0]     pickWrData;
  logic                  isSpm;

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W)
  ) u_arb (
    .req_i   (bus.ChReq),
    .ptr_i   (ptr_q),
    .grant_o (arbGrant),
    .idx_o   (arbIdx),
    .valid_o (arbValid)
  );

  assign pickAddr   = bus.ChAddr[arbIdx*ADDR_W +: ADDR_W];
  assign pickRW     = bus.ChRW[arbIdx];
  assign pickWrData = bus.ChWrData[arbIdx*DATA_W +: DATA_W];
  assign isSpm      = (pickAddr[ADDR_W-1 -: 3] == SPM_TAG);

  assign bus.ChAck     = chAck_q;
  assign bus.ChErr     = chErr_q;
  assign bus.RdData    = rdData_q;
  assign bus.Busy      = busy_q;
  assign bus.SPMAddr   = spmAddr_q;
  assign bus.SPMAs_    = spmAs_q;
  assign bus.SPMRW     = spmRW_q;
  assign bus.SPMWrData = spmWrData_q;
  assign bus.BusReq_   = busReq_q;
  assign bus.BusAddr   = busAddr_q;
  assign bus.BusAs_    = busAs_q;
  assign bus.BusRW     = busRW_q;
  assign bus.BusWrData = busWrData_q;

  // Outputs are loaded on the transition into the state that owns them, so
  // every strobe is a flop and lines up with the state it belongs to.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      selOh_q     <= '0;
      addr_q      <= '0;
      rw_q        <= READ;
      wrData_q    <= '0;
      cnt_q       <= '0;
      chAck_q     <= '0;
      chErr_q     <= 1'b0;
      rdData_q    <= '0;
      busy_q      <= 1'b0;
      spmAddr_q   <= '0;
      spmAs_q     <= DISABLE_;
      spmRW_q     <= READ;
      spmWrData_q <= '0;
      busReq_q    <= DISABLE_;
      busAddr_q   <= '0;
      busAs_q     <= DISABLE_;
      busRW_q     <= READ;
      busWrData_q <= '0;
    end else begin
      chAck_q <= '0;
      chErr_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (arbValid) begin
            selOh_q  <= arbGrant;
            ptr_q    <= IDX_W'((int'(arbIdx) + 1) % NUM_CH);
            addr_q   <= pickAddr;
            rw_q     <= pickRW;
            wrData_q <= pickWrData;
            busy_q   <= 1'b1;
            if (isSpm) begin
              state_q     <= ST_SPM;
              spmAs_q     <= ENABLE_;
              spmAddr_q   <= pickAddr[SPM_ADDR_W-1:0];
              spmRW_q     <= pickRW;
              spmWrData_q <= pickWrData;
            end else begin
              state_q  <= ST_BUS_REQ;
              busReq_q <= ENABLE_;
            end
          end
        end
        ST_SPM: begin
          spmAs_q <= DISABLE_;
          state_q <= ST_SPM_RD;
        end
        ST_SPM_RD: begin
          if (rw_q != WRITE) begin
            rdData_q <= bus.SPMRdData;
          end
          chAck_q <= selOh_q;
          state_q <= ST_DONE;
        end
        ST_BUS_REQ: begin
          if (bus.BusGrnt_ == ENABLE_) begin
            state_q     <= ST_BUS_AS;
            busAs_q     <= ENABLE_;
            busAddr_q   <= addr_q;
            busRW_q     <= rw_q;
            busWrData_q <= wrData_q;
          end
        end
        ST_BUS_AS: begin
          busAs_q <= DISABLE_;
          cnt_q   <= '0;
          state_q <= ST_BUS_WAIT;
        end
        // Ready is tested before the timeout so a last-cycle ready still succeeds.
        ST_BUS_WAIT: begin
          if (bus.BusRdy_ == ENABLE_) begin
            if (rw_q == READ) begin
              rdData_q <= bus.BusRdData;
            end
            chAck_q  <= selOh_q;
            busReq_q <= DISABLE_;
            state_q  <= ST_DONE;
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            chAck_q  <= selOh_q;
            chErr_q  <= 1'b1;
            busReq_q <= DISABLE_;
            state_q  <= ST_DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_DONE: begin
          busReq_q <= DISABLE_;
          busy_q   <= 1'b0;
          state_q  <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_bus_master.sv
// Directed bench: a 2-channel front end with a short timeout and a
// 4-channel, 32-bit-address build for the rotating pointer.
module tb_cpu_bus_master;
  import cpu_bus_pkg::*;

  logic clk;
  logic reset;
  int   checkCount = 0;
  int   errorCount = 0;
  logic [3:0] ack;
  int   cycles;

  cpu_bus_master_if #(.NUM_CH(2), .ADDR_W(30), .DATA_W(32), .SPM_ADDR_W(12)) ifA ();
  cpu_bus_master_if #(.NUM_CH(4), .ADDR_W(32), .DATA_W(32), .SPM_ADDR_W(12)) ifB ();

  cpu_bus_master #(
    .NUM_CH(2), .ADDR_W(30), .DATA_W(32), .SPM_ADDR_W(12), .SPM_TAG(3'b011), .TIMEOUT(4)
  ) dutA (
    .clk   (clk),
    .reset (reset),
    .bus   (ifA)
  );

  cpu_bus_master #(
    .NUM_CH(4), .ADDR_W(32), .DATA_W(32), .SPM_ADDR_W(12), .SPM_TAG(3'b011), .TIMEOUT(255)
  ) dutB (
    .clk   (clk),
    .reset (reset),
    .bus   (ifB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input bit useB, input int ch, input logic [31:0] addr,
                               input logic rw, input logic [31:0] wdata);
    if (useB) begin
      ifB.ChReq[ch]             = 1'b1;
      ifB.ChAddr[ch*32 +: 32]   = addr;
      ifB.ChRW[ch]              = rw;
      ifB.ChWrData[ch*32 +: 32] = wdata;
    end else begin
      ifA.ChReq[ch]             = 1'b1;
      ifA.ChAddr[ch*30 +: 30]   = addr[29:0];
      ifA.ChRW[ch]              = rw;
      ifA.ChWrData[ch*32 +: 32] = wdata;
    end
  endtask

  task automatic dropReq(input bit useB, input int ch);
    if (useB) ifB.ChReq[ch] = 1'b0;
    else      ifA.ChReq[ch] = 1'b0;
  endtask

  // Bounded wait for any acknowledge; an expired bound returns ack = 0.
  task automatic waitAck(input bit useB, input int maxCycles,
                         output logic [3:0] ackSeen, output int n);
    ackSeen = '0;
    n = 0;
    while (n < maxCycles && ackSeen == 4'b0000) begin
      tick();
      n++;
      if (useB) ackSeen = ifB.ChAck;
      else      ackSeen = {2'b00, ifA.ChAck};
    end
  endtask

  task automatic doReset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    ifA.ChReq = '0; ifA.ChAddr = '0; ifA.ChRW = '0; ifA.ChWrData = '0;
    ifA.SPMRdData = '0; ifA.BusGrnt_ = 1'b1; ifA.BusRdData = '0; ifA.BusRdy_ = 1'b1;
    ifB.ChReq = '0; ifB.ChAddr = '0; ifB.ChRW = '0; ifB.ChWrData = '0;
    ifB.SPMRdData = '0; ifB.BusGrnt_ = 1'b1; ifB.BusRdData = '0; ifB.BusRdy_ = 1'b1;
    doReset();

    checkOutput("reset ChAck",   ifA.ChAck,   2'b00);
    checkOutput("reset ChErr",   ifA.ChErr,   1'b0);
    checkOutput("reset RdData",  ifA.RdData,  32'h0);
    checkOutput("reset Busy",    ifA.Busy,    1'b0);
    checkOutput("reset BusReq_", ifA.BusReq_, 1'b1);
    checkOutput("reset BusAs_",  ifA.BusAs_,  1'b1);
    checkOutput("reset SPMAs_",  ifA.SPMAs_,  1'b1);
    checkOutput("reset BusRW",   ifA.BusRW,   1'b1);
    checkOutput("reset SPMRW",   ifA.SPMRW,   1'b1);
    checkOutput("reset BusAddr", ifA.BusAddr, 30'h0);

    // SPM read: address bits [29:27] = 3'b011 select the scratch-pad.
    ifA.SPMRdData = 32'hDEADBEEF;
    applyStimulus(0, 0, 32'h18000005, READ, 32'h0);
    tick();
    checkOutput("spm c1 SPMAs_",  ifA.SPMAs_,  1'b0);
    checkOutput("spm c1 SPMAddr", ifA.SPMAddr, 12'h005);
    checkOutput("spm c1 Busy",    ifA.Busy,    1'b1);
    checkOutput("spm c1 BusReq_", ifA.BusReq_, 1'b1);
    tick();
    checkOutput("spm c2 SPMAs_",  ifA.SPMAs_,  1'b1);
    checkOutput("spm c2 ChAck",   ifA.ChAck,   2'b00);
    tick();
    checkOutput("spm c3 ChAck",   ifA.ChAck,   2'b01);
    checkOutput("spm c3 RdData",  ifA.RdData,  32'hDEADBEEF);
    checkOutput("spm c3 ChErr",   ifA.ChErr,   1'b0);
    dropReq(0, 0);
    tick();
    checkOutput("spm c4 ChAck",   ifA.ChAck,   2'b00);
    checkOutput("spm c4 Busy",    ifA.Busy,    1'b0);

    // Two bus readers from reset, grant and ready always asserted.
    doReset();
    ifA.BusGrnt_ = 1'b0;
    ifA.BusRdy_  = 1'b0;
    ifA.BusRdData = 32'hA5A50001;
    applyStimulus(0, 0, 32'h100, READ, 32'h0);
    applyStimulus(0, 1, 32'h200, READ, 32'h0);
    for (int round = 0; round < 2; round++) begin
      waitAck(0, 20, ack, cycles);
      checkOutput("rr first ch0", ack, 4'b0001);
      if (round == 0) begin
        checkOutput("bus latency", cycles, 4);
        checkOutput("bus RdData",  ifA.RdData, 32'hA5A50001);
      end
      dropReq(0, 0);
      waitAck(0, 20, ack, cycles);
      checkOutput("rr then ch1", ack, 4'b0010);
      dropReq(0, 1);
      if (round == 0) begin
        applyStimulus(0, 0, 32'h100, READ, 32'h0);
        applyStimulus(0, 1, 32'h200, READ, 32'h0);
      end
    end
    ifA.BusGrnt_ = 1'b1;
    ifA.BusRdy_  = 1'b1;
    tick();

    // Ch1 bus write: grant given in the third request cycle, ready in the second wait cycle.
    applyStimulus(0, 1, 32'h100, WRITE, 32'h12345678);
    tick();
    checkOutput("wr c1 BusReq_", ifA.BusReq_, 1'b0);
    checkOutput("wr c1 BusAs_",  ifA.BusAs_,  1'b1);
    tick();
    tick();
    ifA.BusGrnt_ = 1'b0;
    tick();
    checkOutput("wr c4 BusAs_",    ifA.BusAs_,    1'b0);
    checkOutput("wr c4 BusRW",     ifA.BusRW,     1'b0);
    checkOutput("wr c4 BusAddr",   ifA.BusAddr,   30'h100);
    checkOutput("wr c4 BusWrData", ifA.BusWrData, 32'h12345678);
    ifA.BusGrnt_ = 1'b1;
    tick();
    checkOutput("wr c5 BusAs_",  ifA.BusAs_,  1'b1);
    checkOutput("wr c5 BusReq_", ifA.BusReq_, 1'b0);
    tick();
    ifA.BusRdy_ = 1'b0;
    tick();
    checkOutput("wr c7 ChAck", ifA.ChAck, 2'b10);
    checkOutput("wr c7 ChErr", ifA.ChErr, 1'b0);
    checkOutput("wr c7 RdData kept", ifA.RdData, 32'hA5A50001);
    ifA.BusRdy_ = 1'b1;
    dropReq(0, 1);
    tick();
    checkOutput("wr c8 ChAck",   ifA.ChAck,   2'b00);
    checkOutput("wr c8 BusReq_", ifA.BusReq_, 1'b1);

    // Timeout with TIMEOUT=4: acknowledge lands 5 cycles after BusAs_.
    ifA.BusGrnt_ = 1'b0;
    applyStimulus(0, 0, 32'h300, READ, 32'h0);
    tick();
    tick();
    checkOutput("to c2 BusAs_", ifA.BusAs_, 1'b0);
    for (int k = 0; k < 4; k++) begin
      tick();
      checkOutput("to no early ack", ifA.ChAck, 2'b00);
    end
    tick();
    checkOutput("to c7 ChAck",   ifA.ChAck,   2'b01);
    checkOutput("to c7 ChErr",   ifA.ChErr,   1'b1);
    checkOutput("to c7 BusReq_", ifA.BusReq_, 1'b1);
    dropReq(0, 0);
    tick();
    checkOutput("to c8 BusReq_", ifA.BusReq_, 1'b1);
    checkOutput("to c8 ChErr",   ifA.ChErr,   1'b0);

    // Ready in the last wait cycle before timeout: ready wins.
    applyStimulus(0, 1, 32'h304, READ, 32'h0);
    ifA.BusRdData = 32'h0BADF00D;
    for (int k = 0; k < 6; k++) tick();
    ifA.BusRdy_ = 1'b0;
    tick();
    checkOutput("edge ChAck",  ifA.ChAck,  2'b10);
    checkOutput("edge ChErr",  ifA.ChErr,  1'b0);
    checkOutput("edge RdData", ifA.RdData, 32'h0BADF00D);
    ifA.BusRdy_ = 1'b1;
    dropReq(0, 1);
    tick();

    // Reset during BUS_WAIT drops strobes at once and yields no acknowledge.
    applyStimulus(0, 0, 32'h400, READ, 32'h0);
    tick();
    tick();
    checkOutput("rst c2 BusAs_", ifA.BusAs_, 1'b0);
    tick();
    reset = 1'b1;
    #1;
    checkOutput("rst BusReq_", ifA.BusReq_, 1'b1);
    checkOutput("rst BusAs_",  ifA.BusAs_,  1'b1);
    checkOutput("rst Busy",    ifA.Busy,    1'b0);
    dropReq(0, 0);
    ifA.BusGrnt_ = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput("rst no ack", ifA.ChAck, 2'b00);
    end
    applyStimulus(0, 1, 32'h18000010, WRITE, 32'hFEEDF00D);
    tick();
    checkOutput("post SPMAs_",    ifA.SPMAs_,    1'b0);
    checkOutput("post SPMRW",     ifA.SPMRW,     1'b0);
    checkOutput("post SPMAddr",   ifA.SPMAddr,   12'h010);
    checkOutput("post SPMWrData", ifA.SPMWrData, 32'hFEEDF00D);
    tick();
    tick();
    checkOutput("post ChAck",  ifA.ChAck,  2'b10);
    checkOutput("post RdData", ifA.RdData, 32'h0);
    dropReq(0, 1);
    tick();

    // Four channels: after ch1 is served the pointer is 2, so ch3 beats ch1.
    ifB.SPMRdData = 32'h0B0B0B0B;
    applyStimulus(1, 1, 32'h60000001, READ, 32'h0);
    waitAck(1, 10, ack, cycles);
    checkOutput("b ch1 ack",     ack,        4'b0010);
    checkOutput("b spm latency", cycles,     3);
    checkOutput("b RdData",      ifB.RdData, 32'h0B0B0B0B);
    dropReq(1, 1);
    tick();
    applyStimulus(1, 1, 32'h60000001, READ, 32'h0);
    applyStimulus(1, 3, 32'h60000003, READ, 32'h0);
    waitAck(1, 10, ack, cycles);
    checkOutput("b ptr2 ch3 first", ack,         4'b1000);
    checkOutput("b ch3 SPMAddr",    ifB.SPMAddr, 12'h003);
    dropReq(1, 3);
    waitAck(1, 10, ack, cycles);
    checkOutput("b then ch1", ack, 4'b0010);
    dropReq(1, 1);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
